key_event_filter: RTL and testbench

Sits between the keypad scanner and the PWM tone generator. Samples the scanner's 16-bit key snapshot once per completed scan and debounces it over several consecutive scans. Rejects multi-key (ghosting) patterns and produces one stable button code. Emits single-cycle press/release events so the tone generator only re-loads its half-period N on clean transitions.

---
 rtl/kp_pkg.sv | 22 ++
 rtl/key_classify.sv | 24 ++
 rtl/key_event_filter.sv | 142 ++++++++++++++
 tb/tb_key_event_filter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/kp_pkg.sv
// Shared keypad definitions: debounce FSM states, the "no button" code and the
// reference snapshot classifier that the scanner self-check also uses.
package kp_pkg;

   typedef enum logic [1:0] {IDLE, ARMING, HELD, RELEASING} kp_state_e;

   localparam logic [4:0] BTN_NONE = 5'd0;

   // Returns {multi, code}. code is the lowest pressed key index + 1 (0 if none).
   function automatic logic [5:0] key_code(input logic [15:0] keys);
      logic [4:0] code;
      logic [4:0] ones;
      code = BTN_NONE;
      ones = '0;
      for (int i = 15; i >= 0; i--) begin
         if (keys[i]) code = 5'(i + 1);
         ones = ones + 5'(keys[i]);
      end
      return {(ones > 5'd1), code};
   endfunction

endpackage

// File: rtl/key_classify.sv
// Combinational snapshot classifier: zero / one-hot / multi detect plus a
// priority encode of the pressed key into a 1-based button code.
module key_classify
   import kp_pkg::*;
(
   input  logic [15:0] keys,
   output logic        multi,
   output logic [4:0]  code
);

   logic [15:0] rest;

   // Clearing the lowest set bit leaves something only if two or more keys are down.
   assign rest  = keys & (keys - 16'd1);
   assign multi = |rest;

   always_comb begin
      code = BTN_NONE;
      for (int i = 15; i >= 0; i--) begin
         if (keys[i]) code = 5'(i + 1);
      end
   end

endmodule

// File: rtl/key_event_filter.sv
// Debounces per-scan key snapshots into a stable button code and emits
// single-cycle press/release events for the tone generator.
module key_event_filter
   import kp_pkg::*;
#(
   parameter int DEB_SCANS  = 3,
   parameter bit MULTI_HOLD = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        scan,
   input  logic [15:0] keys,
   output logic [4:0]  btn,
   output logic        btn_evt,
   output logic        btn_press,
   output logic        multi_err
);

   localparam int             CW      = $clog2(DEB_SCANS + 1);
   localparam logic [CW-1:0]  DEB_MAX = CW'(DEB_SCANS);
   localparam logic [CW-1:0]  CNT_ONE = CW'(1);

   kp_state_e     state, state_n;
   logic [4:0]    cand, cand_n;
   logic [CW-1:0] cnt, cnt_n, cnt_inc;
   logic [4:0]    btn_n, new_code;
   logic          evt_n, press_n, err_n, commit;
   logic          raw_multi, ignore;
   logic [4:0]    raw_code, code;

   key_classify u_classify (
      .keys  (keys),
      .multi (raw_multi),
      .code  (raw_code)
   );

   // A held multi-key scan is invisible to debounce; otherwise it reads as "no key".
   assign ignore  = raw_multi && MULTI_HOLD;
   assign code    = raw_multi ? BTN_NONE : raw_code;
   assign cnt_inc = (cnt == DEB_MAX) ? cnt : cnt + CNT_ONE;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         cand      <= BTN_NONE;
         cnt       <= '0;
         btn       <= BTN_NONE;
         btn_evt   <= 1'b0;
         btn_press <= 1'b0;
         multi_err <= 1'b0;
      end else begin
         state     <= state_n;
         cand      <= cand_n;
         cnt       <= cnt_n;
         btn       <= btn_n;
         btn_evt   <= evt_n;
         btn_press <= press_n;
         multi_err <= err_n;
      end
   end

   always_comb begin
      state_n  = state;
      cand_n   = cand;
      cnt_n    = cnt;
      btn_n    = btn;
      evt_n    = 1'b0;
      press_n  = btn_press;
      err_n    = multi_err;
      commit   = 1'b0;
      new_code = cand;

      if (scan) begin
         if (raw_multi) err_n = 1'b1;
         if (!ignore) begin
            unique case (state)
               IDLE: begin
                  if (code != BTN_NONE) begin
                     if (DEB_SCANS == 1) begin
                        commit   = 1'b1;
                        new_code = code;
                     end else begin
                        cand_n  = code;
                        cnt_n   = CNT_ONE;
                        state_n = ARMING;
                     end
                  end
               end
               ARMING: begin
                  if (code == cand) begin
                     if (cnt_inc == DEB_MAX) commit = 1'b1;
                     else                    cnt_n  = cnt_inc;
                  end else if (code != BTN_NONE) begin
                     cand_n = code;
                     cnt_n  = CNT_ONE;
                  end else begin
                     cand_n  = BTN_NONE;
                     cnt_n   = '0;
                     state_n = IDLE;
                  end
               end
               HELD: begin
                  if (code == btn) begin
                     cnt_n = '0;
                  end else if (DEB_SCANS == 1) begin
                     commit   = 1'b1;
                     new_code = code;
                  end else begin
                     cand_n  = code;
                     cnt_n   = CNT_ONE;
                     state_n = RELEASING;
                  end
               end
               RELEASING: begin
                  // Bouncing back to the held key cancels the pending change silently.
                  if (code == btn) begin
                     cnt_n   = '0;
                     state_n = HELD;
                  end else if (code == cand) begin
                     if (cnt_inc == DEB_MAX) commit = 1'b1;
                     else                    cnt_n  = cnt_inc;
                  end else begin
                     cand_n = code;
                     cnt_n  = CNT_ONE;
                  end
               end
               default: state_n = IDLE;
            endcase
         end
      end

      if (commit) begin
         btn_n   = new_code;
         cand_n  = new_code;
         cnt_n   = '0;
         evt_n   = 1'b1;
         press_n = (new_code != BTN_NONE);
         state_n = (new_code == BTN_NONE) ? IDLE : HELD;
      end
   end

endmodule

// File: tb/tb_key_event_filter.sv
// Bench for key_event_filter: two instances (multi-hold on/off) against a
// sliding-window debounce model, with directed scenarios and random scans.
module tb_key_event_filter;

   localparam int DEB = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        scan = 1'b0;
   logic [15:0] keys = '0;
   logic [4:0]  btn [2];
   logic        evt [2];
   logic        press [2];
   logic        err [2];

   always #5 clk = ~clk;

   key_event_filter #(.DEB_SCANS(DEB), .MULTI_HOLD(1'b1)) u_hold (
      .clk(clk), .rst(rst), .scan(scan), .keys(keys),
      .btn(btn[0]), .btn_evt(evt[0]), .btn_press(press[0]), .multi_err(err[0])
   );

   key_event_filter #(.DEB_SCANS(DEB), .MULTI_HOLD(1'b0)) u_pass (
      .clk(clk), .rst(rst), .scan(scan), .keys(keys),
      .btn(btn[1]), .btn_evt(evt[1]), .btn_press(press[1]), .multi_err(err[1])
   );

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   // Model: a change commits when the last DEB accepted codes all equal a code
   // that differs from the current button.
   int mbtn [2];
   bit mevt [2];
   bit mpress [2];
   bit merr [2];
   int win [2][DEB];
   int nacc [2];

   int cap_btn [2];
   int cap_evt [2];
   int cap_press [2];
   int cap_err [2];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input bit r, input bit s, input logic [15:0] k);
      int  nb;
      int  c;
      bit  same;
      for (int i = 0; i < 2; i++) begin
         mevt[i] = 1'b0;
         if (!r) begin
            mbtn[i] = 0; mpress[i] = 1'b0; merr[i] = 1'b0; nacc[i] = 0;
         end else if (s) begin
            nb = $countones(k);
            c = 0;
            for (int b = 0; b < 16; b++) if (k[b]) c = b + 1;
            if (nb != 1) c = 0;
            if (nb > 1) merr[i] = 1'b1;
            if (!(nb > 1 && i == 0)) begin
               for (int j = DEB - 1; j > 0; j--) win[i][j] = win[i][j-1];
               win[i][0] = c;
               if (nacc[i] < DEB) nacc[i]++;
               same = 1'b1;
               for (int j = 0; j < DEB; j++) if (win[i][j] != c) same = 1'b0;
               if (nacc[i] == DEB && same && c != mbtn[i]) begin
                  mbtn[i] = c; mevt[i] = 1'b1; mpress[i] = (c != 0);
               end
            end
         end
      end
   endtask

   task automatic cycle(input bit r, input bit s, input logic [15:0] k);
      @(negedge clk);
      rst = r; scan = s; keys = k;
      model_step(r, s, k);
      @(posedge clk);
      #1;
   endtask

   // One scan strobe, capture the outputs it produced, then an idle gap cycle.
   task automatic step(input logic [15:0] k);
      cycle(1'b1, 1'b1, k);
      for (int i = 0; i < 2; i++) begin
         cap_btn[i] = int'(btn[i]); cap_evt[i] = int'(evt[i]);
         cap_press[i] = int'(press[i]); cap_err[i] = int'(err[i]);
      end
      cycle(1'b1, 1'b0, 16'($urandom));
   endtask

   task automatic expect_cap(input string n, input int i, input int b, input int e, input int p);
      chk({n, "_btn"}, cap_btn[i], b);
      chk({n, "_evt"}, cap_evt[i], e);
      if (e != 0) chk({n, "_press"}, cap_press[i], p);
   endtask

   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            chk("cyc_btn", int'(btn[i]), mbtn[i]);
            chk("cyc_evt", int'(evt[i]), int'(mevt[i]));
            chk("cyc_press", int'(press[i]), int'(mpress[i]));
            chk("cyc_err", int'(err[i]), int'(merr[i]));
         end
      end
   end

   initial begin
      logic [15:0] k;
      int a, b, run;

      cycle(1'b0, 1'b0, 16'h0);
      cycle(1'b0, 1'b1, 16'h0020);
      chk_en = 1'b1;
      for (int i = 0; i < 2; i++) begin
         chk("rst_btn", int'(btn[i]), 0);
         chk("rst_evt", int'(evt[i]), 0);
         chk("rst_press", int'(press[i]), 0);
         chk("rst_err", int'(err[i]), 0);
      end

      // Clean press of key 5
      step(16'h0020); expect_cap("press1", 0, 0, 0, 0);
      step(16'h0020); expect_cap("press2", 0, 0, 0, 0);
      step(16'h0020); expect_cap("press3", 0, 6, 1, 1); expect_cap("press3p", 1, 6, 1, 1);

      // Clean release
      step(16'h0000); step(16'h0000); expect_cap("rel2", 0, 6, 0, 0);
      step(16'h0000); expect_cap("rel3", 0, 0, 1, 0);

      // Single zero glitch while held: no event
      repeat (3) step(16'h0020);
      step(16'h0000); expect_cap("glitch0", 0, 6, 0, 0);
      step(16'h0020); step(16'h0020); step(16'h0020); expect_cap("glitch_end", 0, 6, 0, 0);
      repeat (3) step(16'h0000);

      // Bounce on press
      step(16'h0020); step(16'h0000); step(16'h0020); step(16'h0020);
      expect_cap("bounce4", 0, 0, 0, 0);
      step(16'h0020); expect_cap("bounce5", 0, 6, 1, 1);
      repeat (3) step(16'h0000);

      // Key-to-key change without a release event
      repeat (3) step(16'h0001);
      expect_cap("k1", 0, 1, 1, 1);
      step(16'h0080); step(16'h0080); expect_cap("k2k_mid", 0, 1, 0, 0);
      step(16'h0080); expect_cap("k2k", 0, 8, 1, 1);
      repeat (3) step(16'h0001);
      expect_cap("back1", 0, 1, 1, 1);

      // Multi-key while held
      step(16'h0011);
      expect_cap("multi1_h", 0, 1, 0, 0); chk("multi1_err_h", cap_err[0], 1);
      expect_cap("multi1_p", 1, 1, 0, 0); chk("multi1_err_p", cap_err[1], 1);
      step(16'h0011); step(16'h0011);
      expect_cap("multi3_h", 0, 1, 0, 0);
      expect_cap("multi3_p", 1, 0, 1, 0);
      step(16'h0001); step(16'h0001);
      chk("sticky_h", cap_err[0], 1); chk("sticky_p", cap_err[1], 1);

      // Reset mid-arming, including a scan lost to reset
      cycle(1'b0, 1'b0, 16'h0);
      chk("rst2_err", int'(err[0]), 0); chk("rst2_btn", int'(btn[0]), 0);
      step(16'h0020); step(16'h0020);
      cycle(1'b0, 1'b1, 16'h0020);
      chk("rstarm_btn", int'(btn[0]), 0); chk("rstarm_evt", int'(evt[0]), 0);
      step(16'h0020); step(16'h0020); expect_cap("rstarm2", 0, 0, 0, 0);
      step(16'h0020); expect_cap("rstarm3", 0, 6, 1, 1);

      // Reset mid-releasing: button drops with no event
      step(16'h0000); step(16'h0000);
      cycle(1'b0, 1'b0, 16'h0);
      chk("rstrel_btn", int'(btn[0]), 0); chk("rstrel_evt", int'(evt[0]), 0);
      cycle(1'b1, 1'b0, 16'h0);

      // Random runs of patterns
      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3: k = 16'h0;
            4, 5, 6, 7: begin
               a = $urandom_range(0, 3);
               k = 16'h1 << ((a == 0) ? 0 : (a == 1) ? 5 : (a == 2) ? 7 : 15);
            end
            8: begin
               a = $urandom_range(0, 15);
               b = (a + $urandom_range(1, 15)) % 16;
               k = (16'h1 << a) | (16'h1 << b);
            end
            default: k = 16'($urandom);
         endcase
         run = $urandom_range(1, 4);
         for (int r = 0; r < run; r++) begin
            if ($urandom_range(0, 59) == 0) cycle(1'b0, 1'($urandom_range(0, 1)), k);
            else step(k);
            if ($urandom_range(0, 3) == 0) cycle(1'b1, 1'b0, 16'($urandom));
         end
      end

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
